// File: rtl/jk_drive_sequencer.sv
// jk_drive_sequencer: drives J/K excitation for an external JK flop bank and verifies the feedback
module jk_drive_sequencer #(
    parameter int W           = 4,
    parameter bit TOGGLE_PREF = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] target,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    output logic [W-1:0] J,
    output logic [W-1:0] K,
    input  logic [W-1:0] Qfb,
    output logic         mismatch,
    output logic [7:0]   err_count,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
    state_t       state_q, state_d;
    logic [W-1:0] mq_q, mq_d, tq_q, tq_d, j_q, j_d, k_q, k_d;
    logic         mm_q, mm_d, xfer, diff;
    logic [7:0]   err_q, err_d;
    assign tgt_ready = (state_q == IDLE) && !rst;
    assign xfer      = tgt_valid && tgt_ready;
    assign diff      = Qfb != tq_q;
    assign busy      = state_q != IDLE;
    assign J         = j_q;
    assign K         = k_q;
    assign mismatch  = mm_q;
    assign err_count = err_q;
    // next state: latch target and excitation on transfer, verify feedback when leaving CHECK
    always_comb begin
        state_d = state_q;
        mq_d    = mq_q;
        tq_d    = tq_q;
        j_d     = '0;
        k_d     = '0;
        mm_d    = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: if (xfer) begin
                state_d = DRIVE;
                tq_d    = target;
                j_d     = TOGGLE_PREF ? (mq_q ^ target) : (target & ~mq_q);
                k_d     = TOGGLE_PREF ? (mq_q ^ target) : (mq_q & ~target);
            end
            DRIVE: state_d = CHECK;
            CHECK: begin
                state_d = IDLE;
                mm_d    = diff;
                mq_d    = diff ? Qfb : tq_q;
                err_d   = (diff && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and registered outputs; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mq_q    <= '0;
            tq_q    <= '0;
            j_q     <= '0;
            k_q     <= '0;
            mm_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            mq_q    <= mq_d;
            tq_q    <= tq_d;
            j_q     <= j_d;
            k_q     <= k_d;
            mm_q    <= mm_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_jk_drive_sequencer.sv
// tb_jk_drive_sequencer: directed and random checks of both excitation styles against a cycle-distance model
module tb_jk_drive_sequencer;
    localparam int W = 4;
    logic         clk = 1'b0, rst = 1'b1, tgt_valid = 1'b0;
    logic [W-1:0] target = '0, Qfb = '0;
    logic         rdy0, rdy1, mm0, mm1, busy0, busy1;
    logic [W-1:0] j0, k0, j1, k1;
    logic [7:0]   ec0, ec1;
    int           n_vec = 0, n_bad = 0, busy_cnt = 0;
    logic [W-1:0] m_mq = '0, m_tq = '0;
    int           m_err = 0, m_d = 3;
    logic         m_mm = 1'b0;
    always #5 clk = ~clk;
    jk_drive_sequencer #(.W(W), .TOGGLE_PREF(1'b0)) dut0 (
        .clk(clk), .rst(rst), .target(target), .tgt_valid(tgt_valid), .tgt_ready(rdy0),
        .J(j0), .K(k0), .Qfb(Qfb), .mismatch(mm0), .err_count(ec0), .busy(busy0));
    jk_drive_sequencer #(.W(W), .TOGGLE_PREF(1'b1)) dut1 (
        .clk(clk), .rst(rst), .target(target), .tgt_valid(tgt_valid), .tgt_ready(rdy1),
        .J(j1), .K(k1), .Qfb(Qfb), .mismatch(mm1), .err_count(ec1), .busy(busy1));
    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        m_mq = '0; m_tq = '0; m_err = 0; m_d = 3; m_mm = 1'b0;
    endtask
    // m_d counts edges since the last accepted target; 3 or more means idle
    task automatic cyc(input logic v, input logic [W-1:0] t, input logic [W-1:0] q, input logic r);
        logic [W-1:0] ej0, ek0, et;
        logic         idle;
        tgt_valid = v; target = t; Qfb = q; rst = r;
        if (r) model_reset();
        @(negedge clk);
        idle = m_d >= 3;
        ej0  = (m_d == 1) ? (m_tq & ~m_mq) : '0;
        ek0  = (m_d == 1) ? (m_mq & ~m_tq) : '0;
        et   = (m_d == 1) ? (m_tq ^ m_mq) : '0;
        chk("ready0", int'(rdy0), int'(idle && !r));
        chk("ready1", int'(rdy1), int'(idle && !r));
        chk("busy0", int'(busy0), int'(!idle));
        chk("busy1", int'(busy1), int'(!idle));
        chk("J0", int'(j0), int'(ej0));
        chk("K0", int'(k0), int'(ek0));
        chk("J1", int'(j1), int'(et));
        chk("K1", int'(k1), int'(et));
        chk("mm0", int'(mm0), int'(m_mm));
        chk("mm1", int'(mm1), int'(m_mm));
        chk("err0", int'(ec0), m_err);
        chk("err1", int'(ec1), m_err);
        busy_cnt += int'(busy0);
        @(posedge clk);
        if (!r) begin
            m_mm = (m_d == 2) && (q != m_tq);
            if (m_d == 2) begin
                if (m_mm) begin
                    m_mq  = q;
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                end else m_mq = m_tq;
            end
            if (m_d >= 3 && v) begin
                m_tq = t;
                m_d  = 1;
            end else m_d = (m_d < 3) ? m_d + 1 : 3;
        end
        #1;
    endtask
    initial begin
        logic [W-1:0] t, q;
        cyc(0, '0, '0, 1);
        cyc(0, '0, '0, 1);
        cyc(0, '0, '0, 0);
        cyc(1, 4'b1010, '0, 0);
        chk("x032_J", int'(j0), 32'b1010);
        chk("x032_K", int'(k0), 0);
        cyc(0, '0, 4'b1010, 0);
        cyc(0, '0, 4'b1010, 0);
        chk("x032_mm", int'(mm0), 0);
        cyc(1, 4'b0110, 4'b0110, 0);
        chk("x033_J0", int'(j0), 32'b0100);
        chk("x033_K0", int'(k0), 32'b1000);
        chk("x033_J1", int'(j1), 32'b1100);
        chk("x033_K1", int'(k1), 32'b1100);
        cyc(0, '0, 4'b0110, 0);
        cyc(0, '0, 4'b0110, 0);
        cyc(1, 4'b0011, 4'b1111, 0);
        cyc(0, '0, 4'b1111, 0);
        cyc(0, '0, 4'b1111, 0);
        chk("x034_mm", int'(mm0), 1);
        chk("x034_err", int'(ec0), 1);
        cyc(1, 4'b1111, 4'b1111, 0);
        chk("x034_J", int'(j0), 0);
        chk("x034_K", int'(k0), 0);
        chk("x034_mm_drop", int'(mm0), 0);
        cyc(0, '0, 4'b1111, 0);
        cyc(0, '0, 4'b1111, 0);
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) cyc(1, W'($urandom), m_tq, 0);
        chk("x035_busy", busy_cnt, 8);
        for (int i = 0; i < 300; i++) begin
            t = W'($urandom);
            cyc(1, t, ~t, 0);
            cyc(0, W'($urandom), ~t, 0);
            cyc(0, W'($urandom), ~t, 0);
        end
        cyc(0, '0, '0, 0);
        chk("x036_sat", int'(ec0), 255);
        cyc(0, '0, '0, 1);
        cyc(0, '0, '0, 0);
        cyc(1, 4'b0101, '0, 0);
        cyc(0, '0, '0, 1);
        chk("x037_J", int'(j0), 0);
        chk("x037_busy", int'(busy0), 0);
        chk("x037_err", int'(ec0), 0);
        cyc(0, '0, '0, 0);
        cyc(0, '0, '0, 0);
        chk("x037_mm", int'(mm0), 0);
        for (int i = 0; i < 2000; i++) begin
            q = ($urandom_range(3) != 0) ? m_tq : W'($urandom);
            cyc(1'($urandom), W'($urandom), q, $urandom_range(149) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/jk_drive_sequencer.md
JK_DRIVE_SEQUENCER -- requirements
Module: jk_drive_sequencer

Interface
REQ-001 Parameter W, default 4, SHALL set the number of external JK flip-flops driven (bank width).
REQ-002 Parameter TOGGLE_PREF, default 0, SHALL select the excitation style: 0 = set/reset style, 1 = toggle style for changing bits.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port target, input, W bits: desired next bank state.
REQ-007 Port tgt_valid, input, 1 bit: target is valid this cycle.
REQ-008 Port tgt_ready, output, 1 bit: block accepts target this cycle.
REQ-009 Port J, output, W bits: J drive to the bank, one bit per flop.
REQ-010 Port K, output, W bits: K drive to the bank, one bit per flop.
REQ-011 Port Qfb, input, W bits: Q feedback from the bank.
REQ-012 Port mismatch, output, 1 bit: one-cycle pulse when feedback differs from target.
REQ-013 Port err_count, output, 8 bits: saturating count of mismatches.
REQ-014 Port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states (IDLE, DRIVE, CHECK), and J, K, mismatch and the model register SHALL all be registered.
REQ-016 tgt_ready SHALL equal 1 only in IDLE, and a transfer SHALL occur on a rising edge where tgt_valid and tgt_ready are both 1.
REQ-017 On a transfer, the block SHALL latch target, compute J/K per bit from the internal model register mq, and enter DRIVE.
REQ-018 With TOGGLE_PREF=0, J/K SHALL be: mq=0,t=0 -> J=0,K=0; mq=0,t=1 -> J=1,K=0; mq=1,t=0 -> J=0,K=1; mq=1,t=1 -> J=0,K=0.
REQ-019 With TOGGLE_PREF=1, bits where mq != t SHALL get J=1,K=1, and bits where mq == t SHALL get J=0,K=0.
REQ-020 In DRIVE, J/K SHALL hold the computed values for exactly one cycle; the next edge SHALL enter CHECK with J=K=0.
REQ-021 In CHECK, on the exiting edge, the block SHALL compare Qfb with the latched target.
REQ-022 On mismatch, the block SHALL pulse mismatch for one cycle, load mq from Qfb (resync), and increment err_count, saturating at 255.
REQ-023 On a match, the block SHALL load mq from the latched target.
REQ-024 CHECK SHALL always return to IDLE, giving one transfer per 3 cycles minimum; J=K=0 in IDLE.
REQ-025 mismatch SHALL be high in the first IDLE cycle after CHECK only.
REQ-026 tgt_valid while not in IDLE SHALL be ignored, and target changes outside the transfer edge SHALL have no effect.
REQ-027 A target equal to mq SHALL still traverse DRIVE/CHECK with J=K=0 and a feedback check.

Reset
REQ-028 While rst=1, regardless of clk, the block SHALL hold: state=IDLE, J=0, K=0, mq=0, mismatch=0, err_count=0, busy=0, tgt_ready=0.
REQ-029 tgt_ready SHALL rise in the first cycle after rst is deasserted.
REQ-030 Assertion of rst in DRIVE or CHECK SHALL abandon the operation, with no mismatch and no count change.
REQ-031 The model SHALL assume the bank powers up at 0; any divergence SHALL be corrected by the first CHECK resync.

Verification
REQ-032 With W=4 and TOGGLE_PREF=0, target 4'b1010 from reset SHALL give J=1010, K=0000 in DRIVE; bank Q=1010 SHALL give no mismatch and mq=1010.
REQ-033 From mq=1010, target 0110 SHALL give J=0100, K=1000 (TOGGLE_PREF=0); with TOGGLE_PREF=1 it SHALL give J=K=1100.
REQ-034 A forced Qfb=1111 against target 0011 SHALL pulse mismatch once, set err_count=1 and mq=1111; the next target 1111 SHALL give J=K=0000.
REQ-035 With tgt_valid held high continuously, transfers SHALL occur every 3rd cycle, busy SHALL be high for 2 of every 3 cycles, and the target changing during DRIVE SHALL be ignored.
REQ-036 With 300 forced mismatches, err_count SHALL stop at 255.
REQ-037 rst asserted in DRIVE SHALL immediately force J=K=0 and busy=0, with no mismatch pulse and err_count unchanged at 0.
